// File: rtl/cpu_fsm_pkg.sv
// Shared types for the CPU front-panel sequencers (RAM dump and RAM load):
// state encodings, default bus widths and small state-decode helpers.
package cpu_fsm_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_AW = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET_ADDR = 3'd1,
      READ_RAM = 3'd2,
      PRESENT  = 3'd3,
      DONE     = 3'd4
   } dump_state_e;

   // A sequencer owns the RAM bus from address set until the word is handed off.
   function automatic logic is_busy(input dump_state_e s);
      return (s == SET_ADDR) || (s == READ_RAM) || (s == PRESENT);
   endfunction

endpackage

// File: rtl/fsm_dump_ram.sv
// Steps through count RAM words, one address-set / read / present cycle per
// word, and hands each word to a consumer with a valid/ready handshake.
module fsm_dump_ram
   import cpu_fsm_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic          step_clk,
   input  logic          reset_n,
   input  logic          clk_e,
   input  logic          clk_s,
   input  logic          start,
   input  logic [AW-1:0] count,
   input  logic [DW-1:0] bus_in,
   input  logic          dump_ready,
   output logic          dumping,
   output logic          set_address,
   output logic          enable_ram,
   output logic [AW-1:0] address,
   output logic [DW-1:0] dump_data,
   output logic          dump_valid,
   output logic          done
);

   dump_state_e   state_q, state_d;
   logic [AW-1:0] remaining_q, remaining_d;
   logic [AW-1:0] address_q, address_d;
   logic [DW-1:0] dump_data_q, dump_data_d;

   // The RAM is read for the whole READ_RAM step, so the enable phase is not needed.
   logic unused_clk_e;
   assign unused_clk_e = clk_e;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others; blocking here would create ordering races.
   always_ff @(posedge step_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         address_q   <= '0;
         dump_data_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         address_q   <= address_d;
         dump_data_q <= dump_data_d;
      end
   end

   // NOTE: every next-state value is defaulted to hold before the case, so no
   // path through the decode can leave a variable unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      address_d   = address_q;
      dump_data_d = dump_data_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               remaining_d = count;
               address_d   = '0;
               state_d     = (count == '0) ? DONE : SET_ADDR;
            end
         end

         SET_ADDR: begin
            state_d = READ_RAM;
         end

         READ_RAM: begin
            dump_data_d = bus_in;
            state_d     = PRESENT;
         end

         PRESENT: begin
            if (dump_ready) begin
               remaining_d = remaining_q - AW'(1);
               if (remaining_q == AW'(1)) begin
                  // Parking the address at 0 keeps DONE's address output clean.
                  address_d = '0;
                  state_d   = DONE;
               end else begin
                  address_d = address_q + AW'(1);
                  state_d   = SET_ADDR;
               end
            end
         end

         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dumping     = is_busy(state_q);
   assign set_address = (state_q == SET_ADDR) & clk_s;
   assign enable_ram  = (state_q == READ_RAM);
   assign dump_valid  = (state_q == PRESENT);
   assign done        = (state_q == DONE);
   assign address     = address_q;
   assign dump_data   = dump_data_q;

endmodule

// File: tb/tb_fsm_dump_ram.sv
// Self-checking bench for fsm_dump_ram: table of dump runs with a
// scoreboard of expected {address, data} words, plus reset/abort sequences.
module tb_fsm_dump_ram;

   localparam int DW = 8;
   localparam int AW = 8;

   logic          step_clk = 1'b0;
   logic          reset_n;
   logic          clk_e = 1'b0;
   logic          clk_s = 1'b0;
   logic          start;
   logic [AW-1:0] count;
   logic [DW-1:0] bus_in;
   logic          dump_ready;
   logic          dumping;
   logic          set_address;
   logic          enable_ram;
   logic [AW-1:0] address;
   logic [DW-1:0] dump_data;
   logic          dump_valid;
   logic          done;

   logic [DW-1:0] ram [256];

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic [AW-1:0] cnt;
      int            stall;
      bit            toggle_start;
      int            exp_steps;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   int checks = 0;
   int passed = 0;
   int sa_pulses = 0;
   int inv_bad = 0;

   fsm_dump_ram #(.DW(DW), .AW(AW)) dut (
      .step_clk   (step_clk),
      .reset_n    (reset_n),
      .clk_e      (clk_e),
      .clk_s      (clk_s),
      .start      (start),
      .count      (count),
      .bus_in     (bus_in),
      .dump_ready (dump_ready),
      .dumping    (dumping),
      .set_address(set_address),
      .enable_ram (enable_ram),
      .address    (address),
      .dump_data  (dump_data),
      .dump_valid (dump_valid),
      .done       (done)
   );

   // RAM drives a sentinel when not enabled so a stray capture is visible.
   assign bus_in = enable_ram ? ram[address] : 8'hEE;

   always #5 step_clk = ~step_clk;

   always @(posedge step_clk) begin
      #1 clk_s = 1'b1;
      #2 clk_s = 1'b0;
      #1 clk_e = 1'b1;
      #2 clk_e = 1'b0;
   end

   // Observe set_address while the set phase is high.
   always @(posedge clk_s) begin
      #1;
      if (set_address) sa_pulses++;
      if (set_address && enable_ram) inv_bad++;
      if (set_address && (!dumping || dump_valid)) inv_bad++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dumping"},     32'(dumping),     0);
      check({tag, "_set_address"}, 32'(set_address), 0);
      check({tag, "_enable_ram"},  32'(enable_ram),  0);
      check({tag, "_address"},     32'(address),     0);
      check({tag, "_dump_data"},   32'(dump_data),   0);
      check({tag, "_dump_valid"},  32'(dump_valid),  0);
      check({tag, "_done"},        32'(done),        0);
   endtask

   task automatic run_dump(input vec_t v);
      int steps   = 0;
      int popped  = 0;
      int en_cnt  = 0;
      int stall   = v.stall;
      int sa0     = sa_pulses;
      int bad_lo  = 0;
      bit got_done = 1'b0;

      @(negedge step_clk);
      sb.delete();
      for (int i = 0; i < int'(v.cnt); i++)
         sb.push_back('{addr: AW'(i), data: ram[i]});
      count      = v.cnt;
      start      = 1'b1;
      dump_ready = 1'b1;

      for (int s = 0; s < v.exp_steps + 50; s++) begin
         @(negedge step_clk);
         steps++;
         if (set_address) bad_lo++;
         if (enable_ram) en_cnt++;
         if (enable_ram && dump_valid) bad_lo++;
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (v.toggle_start) start = 1'($urandom_range(0, 1));
         if (dump_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(dump_valid), 0);
               dump_ready = 1'b1;
            end else if (popped == 0 && stall > 0) begin
               dump_ready = 1'b0;
               stall--;
               check("stall_address", 32'(address),   32'(sb[0].addr));
               check("stall_data",    32'(dump_data), 32'(sb[0].data));
            end else begin
               exp_t e = sb.pop_front();
               dump_ready = 1'b1;
               check("word_address", 32'(address),   32'(e.addr));
               check("word_data",    32'(dump_data), 32'(e.data));
               popped++;
            end
         end else begin
            dump_ready = 1'($urandom_range(0, 1));
         end
      end

      check("reached_done",   32'(got_done),   1);
      check("step_count",     32'(steps),      32'(v.exp_steps));
      check("words_left",     32'(sb.size()),  0);
      check("set_addr_pulses", 32'(sa_pulses - sa0), 32'(v.cnt));
      check("read_steps",     32'(en_cnt),     32'(v.cnt));
      check("strobe_misuse",  32'(bad_lo),     0);
      check("done_address",   32'(address),    0);
      check("done_dumping",   32'(dumping),    0);
      check("done_valid",     32'(dump_valid), 0);

      // Start held high through DONE must not restart the dump.
      start = 1'b1;
      repeat (3) @(negedge step_clk);
      check("hold_done",      32'(done),    1);
      check("hold_no_dump",   32'(dumping), 0);

      start = 1'b0;
      @(negedge step_clk);
      check("back_idle_done", 32'(done),    0);
      @(negedge step_clk);
      check("idle_quiet",     32'(dumping | dump_valid | done), 0);
   endtask

   initial begin
      int seen_valid;
      bit found;

      for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);
      ram[0] = 8'hA1;
      ram[1] = 8'hB2;
      ram[2] = 8'hC3;

      vecs[0] = '{cnt: 8'd3,   stall: 0, toggle_start: 1'b0, exp_steps: 10};
      vecs[1] = '{cnt: 8'd0,   stall: 0, toggle_start: 1'b0, exp_steps: 1};
      vecs[2] = '{cnt: 8'd2,   stall: 4, toggle_start: 1'b0, exp_steps: 11};
      vecs[3] = '{cnt: 8'd1,   stall: 0, toggle_start: 1'b1, exp_steps: 4};
      vecs[4] = '{cnt: 8'd5,   stall: 2, toggle_start: 1'b1, exp_steps: 18};
      vecs[5] = '{cnt: 8'd255, stall: 0, toggle_start: 1'b0, exp_steps: 766};

      reset_n    = 1'b0;
      start      = 1'b0;
      count      = '0;
      dump_ready = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge step_clk);
      reset_n = 1'b1;

      foreach (vecs[i]) run_dump(vecs[i]);

      // Abort during READ_RAM of word 1.
      @(negedge step_clk);
      count      = 8'd2;
      start      = 1'b1;
      dump_ready = 1'b1;
      found      = 1'b0;
      for (int s = 0; s < 20; s++) begin
         @(negedge step_clk);
         start = 1'b0;
         if (enable_ram && address == 8'd1) begin
            found = 1'b1;
            break;
         end
      end
      check("abort_reached_word1", 32'(found), 1);
      #1 reset_n = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (2) @(negedge step_clk);
      reset_n    = 1'b1;
      seen_valid = 0;
      repeat (4) begin
         @(negedge step_clk);
         if (dump_valid || dumping) seen_valid++;
      end
      check("abort_no_resume", 32'(seen_valid), 0);
      check("abort_data_clear", 32'(dump_data), 0);

      // A fresh start after the abort dumps normally.
      run_dump(vecs[3]);

      check("set_address_invariants", 32'(inv_bad), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fsm_dump_ram.md
FSM_DUMP_RAM -- requirements
Module: fsm_dump_ram

Interface
REQ-001 SHALL have parameter DW, default 8, data bus width.
REQ-002 SHALL have parameter AW, default 8, RAM address width.
REQ-003 SHALL have port step_clk, input, 1, stepper clock from CPU clock gen; sole clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clk_e, input, 1, enable-phase clock from CPU clock gen.
REQ-006 SHALL have port clk_s, input, 1, set-phase clock from CPU clock gen.
REQ-007 SHALL have port start, input, 1, level request to begin a dump.
REQ-008 SHALL have port count, input, AW, number of RAM words to dump; sampled at start.
REQ-009 SHALL have port bus_in, input, DW, data bus driven by RAM while enable_ram is high.
REQ-010 SHALL have port dump_ready, input, 1, consumer accepts dump_data.
REQ-011 SHALL have port dumping, output, 1, dump in progress.
REQ-012 SHALL have port set_address, output, 1, RAM address-set strobe.
REQ-013 SHALL have port enable_ram, output, 1, RAM drives bus_in.
REQ-014 SHALL have port address, output, AW, current RAM address.
REQ-015 SHALL have port dump_data, output, DW, captured RAM word.
REQ-016 SHALL have port dump_valid, output, 1, dump_data valid.
REQ-017 SHALL have port done, output, 1, dump complete.

Function
REQ-018 SHALL implement states IDLE, SET_ADDR, READ_RAM, PRESENT, DONE, registered on step_clk.
REQ-019 IDLE: when start=1 SHALL latch count into remaining and clear address to 0. Next state is DONE if count==0, else SET_ADDR.
REQ-020 SET_ADDR SHALL go unconditionally to READ_RAM, with set_address = (state==SET_ADDR) & clk_s.
REQ-021 READ_RAM: enable_ram SHALL be high for the whole state (not clk_e-gated), so bus_in is stable at the closing edge.
REQ-022 On the step_clk edge leaving READ_RAM, SHALL capture bus_in into dump_data and go to PRESENT.
REQ-023 PRESENT: dump_valid SHALL be high, and dump_data and address SHALL stay stable until dump_ready=1 at a step_clk edge.
REQ-024 On PRESENT handshake, SHALL decrement remaining and increment address (AW-bit). Next state is DONE if new remaining==0, else SET_ADDR.
REQ-025 Each word SHALL take exactly 3 steps when dump_ready is held high; each step of dump_ready low adds one step.
REQ-026 DONE: done=1 and address=0; SHALL return to IDLE when start=0.
REQ-027 start SHALL be ignored outside IDLE; a new dump requires start low then high.
REQ-028 dumping SHALL be high in SET_ADDR, READ_RAM and PRESENT only.
REQ-029 count=255 SHALL visit addresses 0..254 with no wrap; address wrap beyond 2^AW-1 is unreachable.
REQ-030 dump_valid SHALL be 0 in every state except PRESENT.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, address=0, remaining=0, dump_data=0.
REQ-032 During reset, all strobes and status outputs SHALL be 0.
REQ-033 Reset mid-dump SHALL abort without completing the current handshake; after release, a fresh start is needed.

Structure
REQ-034 State encodings and DW/AW defaults SHALL live in shared package cpu_fsm_pkg, which is also used by the RAM load sequencer.
REQ-035 No sub-module SHALL be used; single FSM, all output strobes combinational from state and clk_s.

Verification
REQ-036 Scenario: count=3, RAM={A1,B2,C3}, dump_ready=1 -> dump_valid pulses carry A1, B2, C3 at addresses 0, 1, 2; done after 9 steps plus 1 IDLE step.
REQ-037 Scenario: count=0 with start -> IDLE to DONE in one step; set_address, enable_ram and dump_valid never assert.
REQ-038 Scenario: count=2, dump_ready low for 4 steps on word 0 -> dump_data=RAM[0] and address=0 held stable; word 1 follows normally.
REQ-039 Scenario: reset_n low during READ_RAM of word 1 -> outputs go to 0 asynchronously; no dump_valid for word 1.
REQ-040 Scenario: start toggled during PRESENT, or held high through DONE -> no restart until start=0 then 1.
REQ-041 Scenario: check set_address only during SET_ADDR with clk_s=1, and enable_ram never asserted alongside set_address.
